// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair datapath.
//   FIB_W      : default width of one Fibonacci term
//   fib_pair_t : two consecutive terms; lo is the earlier term, hi the later one
package fib_pkg;

    localparam int FIB_W = 16;

    typedef struct packed {
        logic [FIB_W-1:0] hi;
        logic [FIB_W-1:0] lo;
    } fib_pair_t;

endpackage

// File: rtl/fib_pair_fifo.sv
// Synchronous FIFO holding whole Fibonacci pairs.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset, empties the FIFO
//   push_i   : write wdata_i (ignored when full)
//   wdata_i  : pair to store
//   pop_i    : drop the head entry (ignored when empty)
//   rdata_o  : head entry, valid while !empty_o
//   full_o   : no free slot
//   empty_o  : no stored entry
//   level_o  : number of stored entries, 0..DEPTH
module fib_pair_fifo
    import fib_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fib_pair_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    T            mem_q [DEPTH];
    logic        pushOk;
    logic        popOk;

    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign level_o = wrPtr_q - rdPtr_q;
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
        if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fib_pair_serializer.sv
// Accepts (lo, hi) Fibonacci pairs, buffers them and emits one term per
// handshake, lo first, tagged with a running index and a wrap flag.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   in_valid/in_ready  : pair handshake; in_ready is a registered !full
//   in_lo, in_hi       : earlier and later term of the pair
//   out_valid/out_ready: term handshake; out_valid = FIFO not empty
//   out_num            : current term (0 while nothing is stored)
//   out_idx            : term index since reset, modulo 2**IDX_W
//   out_wrap           : current term is below the last consumed term
//   level              : pairs currently stored
module fib_pair_serializer
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_W,
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_lo,
    input  logic [WIDTH-1:0]         in_hi,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_num,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_wrap,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } pair_t;

    pair_t            wrPair;
    pair_t            head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             fire;

    logic             phase_q,    phase_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [WIDTH-1:0] last_q,     last_d;
    logic             consumed_q, consumed_d;
    logic             ready_q,    ready_d;
    logic [LW-1:0]    level_d;

    assign wrPair = '{hi: in_hi, lo: in_lo};
    assign push   = in_valid && ready_q;
    assign fire   = out_valid && out_ready;
    assign pop    = fire && phase_q;

    fib_pair_fifo #(
        .DEPTH (DEPTH),
        .T     (pair_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wrPair),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign in_ready  = ready_q;
    assign out_valid = !empty;
    assign out_idx   = idx_q;
    assign out_num   = empty ? '0 : (phase_q ? head.hi : head.lo);

    // The very first term after reset has nothing to compare against.
    assign out_wrap  = out_valid && consumed_q && (out_num < last_q);

    // in_ready is registered from the level the FIFO will hold next cycle,
    // so it never depends combinationally on out_ready; full is folded in
    // through that same next-level value.
    always_comb begin
        phase_d    = phase_q;
        idx_d      = idx_q;
        last_d     = last_q;
        consumed_d = consumed_q;
        level_d    = level + LW'(push) - LW'(pop);
        ready_d    = (level_d != LW'(DEPTH)) && !(full && !pop);
        if (fire) begin
            phase_d    = !phase_q;
            idx_d      = idx_q + 1'b1;
            last_d     = out_num;
            consumed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= 1'b0;
            idx_q      <= '0;
            last_q     <= '0;
            consumed_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            consumed_q <= consumed_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed self-checking bench for fib_pair_serializer: one default instance
// (DEPTH=4, IDX_W=8) and one with a 3-bit index to exercise index wrap.
module tb_fib_pair_serializer;

    logic        clk;
    logic        rst;

    logic        aInValid, aInReady, aOutValid, aOutReady, aOutWrap;
    logic [15:0] aInLo, aInHi, aOutNum;
    logic [7:0]  aOutIdx;
    logic [2:0]  aLevel;

    logic        bInValid, bInReady, bOutValid, bOutReady, bOutWrap;
    logic [15:0] bInLo, bInHi, bOutNum;
    logic [2:0]  bOutIdx;
    logic [2:0]  bLevel;

    int checks;
    int errors;
    int expIdxA;

    fib_pair_serializer #(.WIDTH(16), .DEPTH(4), .IDX_W(8)) dutA (
        .clk(clk), .rst(rst),
        .in_valid(aInValid), .in_ready(aInReady), .in_lo(aInLo), .in_hi(aInHi),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_num(aOutNum),
        .out_idx(aOutIdx), .out_wrap(aOutWrap), .level(aLevel)
    );

    fib_pair_serializer #(.WIDTH(16), .DEPTH(4), .IDX_W(3)) dutB (
        .clk(clk), .rst(rst),
        .in_valid(bInValid), .in_ready(bInReady), .in_lo(bInLo), .in_hi(bInHi),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_num(bOutNum),
        .out_idx(bOutIdx), .out_wrap(bOutWrap), .level(bLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (aInReady !== 1'b0 || aOutValid !== 1'b0 || aLevel !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_flags got ready=%b valid=%b level=%0d want 0 0 0",
                     aInReady, aOutValid, aLevel);
        end
        checks++;
        if (aOutIdx !== 8'd0 || aOutNum !== 16'd0 || aOutWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data got idx=%0d num=%0d wrap=%b want 0 0 0",
                     aOutIdx, aOutNum, aOutWrap);
        end
        rst = 1'b0;
        step();
        checks++;
        if (aInReady !== 1'b1 || bInReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset got a=%b b=%b want 1 1", aInReady, bInReady);
        end
        expIdxA = 0;
    endtask

    task automatic test_back_to_back();
        int lo [3] = '{1, 2, 5};
        int hi [3] = '{1, 3, 8};
        int expNum [6] = '{1, 1, 2, 3, 5, 8};
        int p, k;
        logic acc, fire;
        aOutReady = 1'b1;
        aInLo = 16'(lo[0]); aInHi = 16'(hi[0]); aInValid = 1'b1;
        step();
        checks++;
        if (aOutValid !== 1'b1 || aOutNum !== 16'd1) begin
            errors++;
            $display("[TB] FAIL b2b_first_valid got valid=%b num=%0d want 1 1", aOutValid, aOutNum);
        end
        p = 1; k = 0;
        aInLo = 16'(lo[1]); aInHi = 16'(hi[1]);
        for (int c = 0; c < 40 && k < 6; c++) begin
            if (aOutValid) begin
                checks++;
                if (aOutNum !== 16'(expNum[k]) || aOutIdx !== 8'(expIdxA + k) || aOutWrap !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_term%0d got num=%0d idx=%0d wrap=%b want %0d %0d 0",
                             k, aOutNum, aOutIdx, aOutWrap, expNum[k], expIdxA + k);
                end
            end
            acc  = aInValid && aInReady;
            fire = aOutValid && aOutReady;
            step();
            if (acc) p++;
            if (fire) k++;
            if (p < 3) begin
                aInLo = 16'(lo[p]); aInHi = 16'(hi[p]);
            end else begin
                aInValid = 1'b0;
            end
        end
        checks++;
        if (k !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d terms want 6", k);
        end
        aOutReady = 1'b0;
        expIdxA += 6;
    endtask

    task automatic test_fill();
        int lo [5] = '{13, 34, 89, 233, 610};
        int hi [5] = '{21, 55, 144, 377, 987};
        int expNum [8] = '{34, 55, 89, 144, 233, 377, 610, 987};
        int k;
        logic fire;
        aOutReady = 1'b0;
        for (int p = 0; p < 4; p++) begin
            aInLo = 16'(lo[p]); aInHi = 16'(hi[p]); aInValid = 1'b1;
            checks++;
            if (aInReady !== 1'b1) begin
                errors++;
                $display("[TB] FAIL fill_ready%0d got %b want 1", p, aInReady);
            end
            step();
            checks++;
            if (aLevel !== 3'(p + 1)) begin
                errors++;
                $display("[TB] FAIL fill_level%0d got %0d want %0d", p, aLevel, p + 1);
            end
        end
        aInLo = 16'(lo[4]); aInHi = 16'(hi[4]);
        checks++;
        if (aInReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ready got %b want 0", aInReady);
        end
        step();
        step();
        checks++;
        if (aLevel !== 3'd4 || aInReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_hold got level=%0d ready=%b want 4 0", aLevel, aInReady);
        end
        checks++;
        if (aOutNum !== 16'd13 || aOutIdx !== 8'(expIdxA)) begin
            errors++;
            $display("[TB] FAIL full_head got num=%0d idx=%0d want 13 %0d", aOutNum, aOutIdx, expIdxA);
        end
        aOutReady = 1'b1;
        step();
        checks++;
        if (aOutNum !== 16'd21 || aOutIdx !== 8'(expIdxA + 1) || aLevel !== 3'd4) begin
            errors++;
            $display("[TB] FAIL fill_hi got num=%0d idx=%0d level=%0d want 21 %0d 4",
                     aOutNum, aOutIdx, aLevel, expIdxA + 1);
        end
        aOutReady = 1'b0;
        aOutReady = 1'b1;
        step();
        aOutReady = 1'b0;
        checks++;
        if (aLevel !== 3'd3 || aInReady !== 1'b1 || aOutNum !== 16'd34) begin
            errors++;
            $display("[TB] FAIL fill_pop got level=%0d ready=%b num=%0d want 3 1 34",
                     aLevel, aInReady, aOutNum);
        end
        step();
        aInValid = 1'b0;
        checks++;
        if (aLevel !== 3'd4 || aInReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_fifth got level=%0d ready=%b want 4 0", aLevel, aInReady);
        end
        expIdxA += 2;
        aOutReady = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            if (aOutValid) begin
                checks++;
                if (aOutNum !== 16'(expNum[k]) || aOutIdx !== 8'(expIdxA + k) || aOutWrap !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL drain_term%0d got num=%0d idx=%0d wrap=%b want %0d %0d 0",
                             k, aOutNum, aOutIdx, aOutWrap, expNum[k], expIdxA + k);
                end
            end
            fire = aOutValid && aOutReady;
            step();
            if (fire) k++;
        end
        checks++;
        if (k !== 8 || aOutValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_count got %0d valid=%b want 8 0", k, aOutValid);
        end
        aOutReady = 1'b0;
        expIdxA += 8;
    endtask

    task automatic test_stall();
        aOutReady = 1'b0;
        aInLo = 16'd1597; aInHi = 16'd2584; aInValid = 1'b1;
        step();
        aInValid = 1'b0;
        checks++;
        if (aOutValid !== 1'b1 || aOutNum !== 16'd1597 || aOutIdx !== 8'(expIdxA) || aOutWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_lo got valid=%b num=%0d idx=%0d wrap=%b want 1 1597 %0d 0",
                     aOutValid, aOutNum, aOutIdx, aOutWrap, expIdxA);
        end
        aOutReady = 1'b1;
        step();
        aOutReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (aOutNum !== 16'd2584 || aOutIdx !== 8'(expIdxA + 1) || aOutValid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got num=%0d idx=%0d valid=%b want 2584 %0d 1",
                         c, aOutNum, aOutIdx, aOutValid, expIdxA + 1);
            end
            if (c < 2) step();
        end
        aOutReady = 1'b1;
        step();
        aOutReady = 1'b0;
        checks++;
        if (aOutValid !== 1'b0 || aOutIdx !== 8'(expIdxA + 2) || aLevel !== 3'd0) begin
            errors++;
            $display("[TB] FAIL stall_done got valid=%b idx=%0d level=%0d want 0 %0d 0",
                     aOutValid, aOutIdx, aLevel, expIdxA + 2);
        end
        expIdxA += 2;
    endtask

    task automatic test_wrap();
        int lo [2] = '{17711, 46368};
        int hi [2] = '{28657, 9489};
        int expNum [4] = '{17711, 28657, 46368, 9489};
        logic expWrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int p, k;
        logic acc, fire;
        aOutReady = 1'b1;
        p = 0; k = 0;
        aInLo = 16'(lo[0]); aInHi = 16'(hi[0]); aInValid = 1'b1;
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (aOutValid) begin
                checks++;
                if (aOutNum !== 16'(expNum[k]) || aOutIdx !== 8'(expIdxA + k) || aOutWrap !== expWrap[k]) begin
                    errors++;
                    $display("[TB] FAIL wrap_term%0d got num=%0d idx=%0d wrap=%b want %0d %0d %b",
                             k, aOutNum, aOutIdx, aOutWrap, expNum[k], expIdxA + k, expWrap[k]);
                end
            end
            acc  = aInValid && aInReady;
            fire = aOutValid && aOutReady;
            step();
            if (acc) p++;
            if (fire) k++;
            if (p < 2) begin
                aInLo = 16'(lo[p]); aInHi = 16'(hi[p]);
            end else begin
                aInValid = 1'b0;
            end
        end
        checks++;
        if (k !== 4) begin
            errors++;
            $display("[TB] FAIL wrap_count got %0d want 4", k);
        end
        aOutReady = 1'b0;
        expIdxA += 4;
    endtask

    task automatic test_reset_mid();
        int lo [3] = '{1, 3, 8};
        int hi [3] = '{2, 5, 13};
        aOutReady = 1'b0;
        for (int p = 0; p < 3; p++) begin
            aInLo = 16'(lo[p]); aInHi = 16'(hi[p]); aInValid = 1'b1;
            step();
        end
        aInValid = 1'b0;
        aOutReady = 1'b1;
        step();
        aOutReady = 1'b0;
        checks++;
        if (aLevel !== 3'd3 || aOutNum !== 16'd2 || aOutIdx !== 8'(expIdxA + 1)) begin
            errors++;
            $display("[TB] FAIL rmid_before got level=%0d num=%0d idx=%0d want 3 2 %0d",
                     aLevel, aOutNum, aOutIdx, expIdxA + 1);
        end
        rst = 1'b1;
        step();
        checks++;
        if (aOutValid !== 1'b0 || aLevel !== 3'd0 || aOutIdx !== 8'd0 || aInReady !== 1'b0 ||
            aOutNum !== 16'd0 || aOutWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_reset got valid=%b level=%0d idx=%0d ready=%b num=%0d wrap=%b want 0 0 0 0 0 0",
                     aOutValid, aLevel, aOutIdx, aInReady, aOutNum, aOutWrap);
        end
        rst = 1'b0;
        step();
        checks++;
        if (aInReady !== 1'b1 || aOutValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_release got ready=%b valid=%b want 1 0", aInReady, aOutValid);
        end
        aInLo = 16'd21; aInHi = 16'd34; aInValid = 1'b1;
        step();
        aInValid = 1'b0;
        checks++;
        if (aOutValid !== 1'b1 || aOutNum !== 16'd21 || aOutIdx !== 8'd0 || aOutWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_first got valid=%b num=%0d idx=%0d wrap=%b want 1 21 0 0",
                     aOutValid, aOutNum, aOutIdx, aOutWrap);
        end
        aOutReady = 1'b1;
        step();
        checks++;
        if (aOutNum !== 16'd34 || aOutIdx !== 8'd1 || aOutWrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_second got num=%0d idx=%0d wrap=%b want 34 1 0",
                     aOutNum, aOutIdx, aOutWrap);
        end
        step();
        aOutReady = 1'b0;
        checks++;
        if (aOutValid !== 1'b0 || aOutIdx !== 8'd2) begin
            errors++;
            $display("[TB] FAIL rmid_empty got valid=%b idx=%0d want 0 2", aOutValid, aOutIdx);
        end
        expIdxA = 2;
    endtask

    task automatic test_idx_wrap();
        int lo [5] = '{1, 2, 5, 13, 34};
        int hi [5] = '{1, 3, 8, 21, 55};
        int expNum [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
        int p, k;
        logic acc, fire;
        bOutReady = 1'b1;
        p = 0; k = 0;
        bInLo = 16'(lo[0]); bInHi = 16'(hi[0]); bInValid = 1'b1;
        for (int c = 0; c < 60 && k < 10; c++) begin
            if (bOutValid) begin
                checks++;
                if (bOutNum !== 16'(expNum[k]) || bOutIdx !== 3'(k % 8) || bOutWrap !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idxw_term%0d got num=%0d idx=%0d wrap=%b want %0d %0d 0",
                             k, bOutNum, bOutIdx, bOutWrap, expNum[k], k % 8);
                end
            end
            acc  = bInValid && bInReady;
            fire = bOutValid && bOutReady;
            step();
            if (acc) p++;
            if (fire) k++;
            if (p < 5) begin
                bInLo = 16'(lo[p]); bInHi = 16'(hi[p]);
            end else begin
                bInValid = 1'b0;
            end
        end
        checks++;
        if (k !== 10 || bOutIdx !== 3'd2) begin
            errors++;
            $display("[TB] FAIL idxw_count got %0d idx=%0d want 10 2", k, bOutIdx);
        end
        bOutReady = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expIdxA = 0;
        rst = 1'b1;
        aInValid = 1'b0; aInLo = '0; aInHi = '0; aOutReady = 1'b0;
        bInValid = 1'b0; bInLo = '0; bInHi = '0; bOutReady = 1'b0;
        $display("[TB] start");
        test_reset();
        test_back_to_back();
        test_fill();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_idx_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
